// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Seven-segment types and active-low segment patterns
//                ({g,f,e,d,c,b,a}) shared by the BCD display scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;

    localparam seg_t SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/bcd_display_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_scanner_if
//  Description : Digit/segment bundle between the counter chain (master) and
//                the display scanner (slave). Optional decimal-point signals
//                exist only when BCD_DISPLAY_SCANNER_DP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_display_scanner_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    seg_t                    seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;
`ifdef BCD_DISPLAY_SCANNER_DP_EN
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [0:0]              dp;
`endif

    modport master (
`ifdef BCD_DISPLAY_SCANNER_DP_EN
        output dp_in,
        input  dp,
`endif
        output enable,
        output bcd_in,
        input  seg,
        input  an,
        input  frame_done
    );

    modport slave (
`ifdef BCD_DISPLAY_SCANNER_DP_EN
        input  dp_in,
        output dp,
`endif
        input  enable,
        input  bcd_in,
        output seg,
        output an,
        output frame_done
    );

endinterface : bcd_display_scanner_if
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational BCD to active-low seven-segment decoder with
//                blank override; codes 10..15 show a dash.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_DIGIT[0];
                4'd1:    seg = SEG_DIGIT[1];
                4'd2:    seg = SEG_DIGIT[2];
                4'd3:    seg = SEG_DIGIT[3];
                4'd4:    seg = SEG_DIGIT[4];
                4'd5:    seg = SEG_DIGIT[5];
                4'd6:    seg = SEG_DIGIT[6];
                4'd7:    seg = SEG_DIGIT[7];
                4'd8:    seg = SEG_DIGIT[8];
                4'd9:    seg = SEG_DIGIT[9];
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_scanner
//  Description : Time-multiplexed common-anode 7-seg scanner with per-frame
//                digit snapshot and optional leading-zero blanking.
//                Define BCD_DISPLAY_SCANNER_DP_EN to add decimal-point support.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int LZB         = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_display_scanner_if.slave  bus
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snapshot_q, snapshot_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    seg_t                    seg_q, seg_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              cur_digit;
    logic                    cur_blank;
    seg_t                    dec_seg;

    assign tick = bus.enable && (div_cnt_q == DIV_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);

    // A digit blanks only if it and every more-significant digit are zero;
    // digit 0 always stays lit.
    always_comb begin
        logic seen_nz;
        seen_nz    = 1'b0;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            seen_nz       = seen_nz | (snapshot_q[4*i +: 4] != 4'd0);
            blank_mask[i] = (LZB != 0) && !seen_nz;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = snapshot_q[4*i +: 4];
                cur_blank = blank_mask[i];
            end
        end
    end

    seg7_decode u_decode (
        .bcd   (cur_digit),
        .blank (cur_blank),
        .seg   (dec_seg)
    );

    always_comb begin
        div_cnt_d    = div_cnt_q;
        idx_d        = idx_q;
        an_d         = an_q;
        seg_d        = seg_q;
        snapshot_d   = wrap ? bus.bcd_in : snapshot_q;
        frame_done_d = wrap;
        if (bus.enable) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            snapshot_q   <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            snapshot_q   <= snapshot_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;

`ifdef BCD_DISPLAY_SCANNER_DP_EN
    logic [NUM_DIGITS-1:0] dp_snap_q, dp_snap_d;
    logic                  dp_q, dp_d;
    logic                  cur_dp;

    always_comb begin
        cur_dp = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dp = dp_snap_q[i];
            end
        end
    end

    // Decimal point ignores blanking so a lit DP survives on a blank digit.
    always_comb begin
        dp_snap_d = wrap ? bus.dp_in : dp_snap_q;
        dp_d      = bus.enable ? ~cur_dp : dp_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_snap_q <= '0;
            dp_q      <= 1'b1;
        end else begin
            dp_snap_q <= dp_snap_d;
            dp_q      <= dp_d;
        end
    end

    assign bus.dp = dp_q;
`endif

endmodule : bcd_display_scanner
`default_nettype wire
